// File: rtl/camera_stream_gen_if.sv
// Camera emulator port bundle: frame request/seed in, DVP-style stream and status out.
// The master side is the emulator; the slave side is whatever requests frames and
// consumes the stream.
interface camera_stream_gen_if;
   logic       start;
   logic [7:0] seed;
   logic       camera_vsync;
   logic       camera_hsync;
   logic       camera_pclk;
   logic [7:0] camera_data;
   logic       busy;
   logic       frame_done;
   logic [7:0] frame_count;

   modport master (
      input  start, seed,
      output camera_vsync, camera_hsync, camera_pclk, camera_data,
      output busy, frame_done, frame_count
   );

   modport slave (
      output start, seed,
      input  camera_vsync, camera_hsync, camera_pclk, camera_data,
      input  busy, frame_done, frame_count
   );
endinterface

// File: rtl/camera_stream_gen.sv
// On-chip camera emulator. Emits one JPEG-framed byte stream (FF D8, seeded
// payload, FF D9) per accepted start, on a free-running divided pixel clock.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no frame; an accepted start arms the sequencer (busy=1)
// S_VSYNC | vsync at its active level for VSYNC_CYCLES pclk periods
// S_FRONT | vsync inactive, waiting FRONT_PORCH periods before line 0
// S_LINE  | hsync high, one payload byte per pclk period
// S_GAP   | hsync low, data 0x00 for LINE_GAP periods between lines
module camera_stream_gen #(
   parameter int PCLK_DIV       = 2,
   parameter int LINES          = 4,
   parameter int BYTES_PER_LINE = 16,
   parameter int VSYNC_CYCLES   = 8,
   parameter int FRONT_PORCH    = 4,
   parameter int LINE_GAP       = 4,
   parameter bit VSYNC_ACTIVE   = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   camera_stream_gen_if.master   cam
);

   localparam int N    = LINES * BYTES_PER_LINE;
   localparam int KW   = $clog2(N + 1);
   localparam int LW   = $clog2(LINES + 1);
   localparam int DW   = $clog2(PCLK_DIV + 1);
   localparam int PM0  = (VSYNC_CYCLES > FRONT_PORCH) ? VSYNC_CYCLES : FRONT_PORCH;
   localparam int PM1  = (BYTES_PER_LINE > LINE_GAP) ? BYTES_PER_LINE : LINE_GAP;
   localparam int PMAX = (PM0 > PM1) ? PM0 : PM1;
   localparam int PW   = $clog2(PMAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_VSYNC,
      S_FRONT,
      S_LINE,
      S_GAP
   } state_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   div_q;
   logic            pclk_q;
   logic [PW-1:0]   pcnt_q, pcnt_d;
   logic [LW-1:0]   line_q, line_d;
   logic [KW-1:0]   k_q, k_d;
   logic [7:0]      seed_q, seed_d;
   logic            busy_q, busy_d;
   logic            vsync_q, vsync_d;
   logic            hsync_q, hsync_d;
   logic [7:0]      data_q, data_d;
   logic            done_q, done_d;
   logic [7:0]      count_q, count_d;
   logic            fall_tick;

   // Byte k of the frame: SOI marker, seeded payload with 0xFF folded to 0x00, EOI marker.
   function automatic logic [7:0] frame_byte(input logic [KW-1:0] k, input logic [7:0] s);
      logic [7:0] p;
      p = s + 8'(k);
      if (k == KW'(0))          return 8'hFF;
      else if (k == KW'(1))     return 8'hD8;
      else if (k == KW'(N - 2)) return 8'hFF;
      else if (k == KW'(N - 1)) return 8'hD9;
      else if (p == 8'hFF)      return 8'h00;
      else                      return p;
   endfunction

   // The cycle in which pclk is about to be driven low paces the whole sequencer.
   assign fall_tick = (div_q == '0) && pclk_q;

   // Free-running pixel clock divider; toggles pclk every PCLK_DIV clk cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_q  <= DW'(PCLK_DIV - 1);
         pclk_q <= 1'b0;
      end else if (div_q == '0) begin
         div_q  <= DW'(PCLK_DIV - 1);
         pclk_q <= ~pclk_q;
      end else begin
         div_q  <= div_q - DW'(1);
      end
   end

   // Sequencer and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         pcnt_q  <= '0;
         line_q  <= '0;
         k_q     <= '0;
         seed_q  <= 8'h00;
         busy_q  <= 1'b0;
         vsync_q <= ~VSYNC_ACTIVE;
         hsync_q <= 1'b0;
         data_q  <= 8'h00;
         done_q  <= 1'b0;
         count_q <= 8'h00;
      end else begin
         state_q <= state_d;
         pcnt_q  <= pcnt_d;
         line_q  <= line_d;
         k_q     <= k_d;
         seed_q  <= seed_d;
         busy_q  <= busy_d;
         vsync_q <= vsync_d;
         hsync_q <= hsync_d;
         data_q  <= data_d;
         done_q  <= done_d;
         count_q <= count_d;
      end
   end

   // Next state: every change except start acceptance waits for a fall tick, so the
   // receiver always sees stable data across the pclk rising edge.
   always_comb begin
      state_d = state_q;
      pcnt_d  = pcnt_q;
      line_d  = line_q;
      k_d     = k_q;
      seed_d  = seed_q;
      busy_d  = busy_q;
      vsync_d = vsync_q;
      hsync_d = hsync_q;
      data_d  = data_q;
      done_d  = 1'b0;
      count_d = count_q;

      case (state_q)
         S_IDLE: begin
            if (cam.start && !busy_q) begin
               busy_d = 1'b1;
               seed_d = cam.seed;
            end else if (busy_q && fall_tick) begin
               state_d = S_VSYNC;
               vsync_d = VSYNC_ACTIVE;
               pcnt_d  = PW'(VSYNC_CYCLES - 1);
               line_d  = LW'(LINES - 1);
               k_d     = '0;
            end
         end
         S_VSYNC: begin
            if (fall_tick) begin
               if (pcnt_q == '0) begin
                  state_d = S_FRONT;
                  vsync_d = ~VSYNC_ACTIVE;
                  pcnt_d  = PW'(FRONT_PORCH - 1);
               end else begin
                  pcnt_d  = pcnt_q - PW'(1);
               end
            end
         end
         S_FRONT: begin
            if (fall_tick) begin
               if (pcnt_q == '0) begin
                  state_d = S_LINE;
                  hsync_d = 1'b1;
                  data_d  = frame_byte(k_q, seed_q);
                  k_d     = k_q + KW'(1);
                  pcnt_d  = PW'(BYTES_PER_LINE - 1);
               end else begin
                  pcnt_d  = pcnt_q - PW'(1);
               end
            end
         end
         S_LINE: begin
            if (fall_tick) begin
               if (pcnt_q == '0) begin
                  state_d = S_GAP;
                  hsync_d = 1'b0;
                  data_d  = 8'h00;
                  pcnt_d  = PW'(LINE_GAP - 1);
               end else begin
                  data_d  = frame_byte(k_q, seed_q);
                  k_d     = k_q + KW'(1);
                  pcnt_d  = pcnt_q - PW'(1);
               end
            end
         end
         S_GAP: begin
            if (fall_tick) begin
               if (pcnt_q != '0) begin
                  pcnt_d  = pcnt_q - PW'(1);
               end else if (line_q == '0) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  count_d = count_q + 8'd1;
               end else begin
                  state_d = S_LINE;
                  line_d  = line_q - LW'(1);
                  hsync_d = 1'b1;
                  data_d  = frame_byte(k_q, seed_q);
                  k_d     = k_q + KW'(1);
                  pcnt_d  = PW'(BYTES_PER_LINE - 1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign cam.camera_pclk  = pclk_q;
   assign cam.camera_vsync = vsync_q;
   assign cam.camera_hsync = hsync_q;
   assign cam.camera_data  = data_q;
   assign cam.busy         = busy_q;
   assign cam.frame_done   = done_q;
   assign cam.frame_count  = count_q;

endmodule

// File: tb/tb_camera_stream_gen.sv
// Directed bench for camera_stream_gen: a default-parameter instance for frame
// content/timing checks and a minimal-frame instance for the frame counter wrap.
module tb_camera_stream_gen;

   logic clk;
   logic reset;

   camera_stream_gen_if if0 ();
   camera_stream_gen_if if1 ();

   camera_stream_gen u_dut (
      .clk   (clk),
      .reset (reset),
      .cam   (if0.master)
   );

   camera_stream_gen #(
      .PCLK_DIV       (1),
      .LINES          (1),
      .BYTES_PER_LINE (4),
      .VSYNC_CYCLES   (1),
      .FRONT_PORCH    (1),
      .LINE_GAP       (1),
      .VSYNC_ACTIVE   (1'b0)
   ) u_small (
      .clk   (clk),
      .reset (reset),
      .cam   (if1.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Monitor state (each variable written by one process only).
   int         cyc = 0;
   int         t_vs = 0;
   int         t_done = 0;
   int         done_cnt = 0;
   logic       prev_v = 1'b1;
   logic [7:0] q[$];
   int         blen[$];
   logic       prev_h = 1'b0;
   int         done1_cnt = 0;
   int         run1 = 0;
   int         max_run1 = 0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (prev_v && !if0.camera_vsync) t_vs <= cyc;
      prev_v <= if0.camera_vsync;
      if (if0.frame_done) begin
         done_cnt <= done_cnt + 1;
         t_done   <= cyc;
      end
      if (if1.frame_done) begin
         done1_cnt <= done1_cnt + 1;
         run1      <= run1 + 1;
         if (run1 + 1 > max_run1) max_run1 <= run1 + 1;
      end else begin
         run1 <= 0;
      end
   end

   always @(posedge if0.camera_pclk) begin
      if (if0.camera_hsync) begin
         q.push_back(if0.camera_data);
         if (!prev_h) blen.push_back(1);
         else         blen[blen.size()-1] = blen[blen.size()-1] + 1;
      end
      prev_h = if0.camera_hsync;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] model(input int k, input logic [7:0] s, input int n);
      logic [7:0] p;
      p = s + 8'(k);
      if (k == 0)          return 8'hFF;
      else if (k == 1)     return 8'hD8;
      else if (k == n - 2) return 8'hFF;
      else if (k == n - 1) return 8'hD9;
      else if (p == 8'hFF) return 8'h00;
      else                 return p;
   endfunction

   task automatic wait_done0(input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim && !ok; i++) begin
         @(negedge clk);
         if (if0.frame_done) ok = 1'b1;
      end
   endtask

   task automatic wait_done1(input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim && !ok; i++) begin
         @(negedge clk);
         if (if1.frame_done) ok = 1'b1;
      end
   endtask

   task automatic pulse_start0(input logic [7:0] s);
      if0.start = 1'b1;
      if0.seed  = s;
      @(negedge clk);
      if0.start = 1'b0;
      if0.seed  = 8'h00;
   endtask

   // Checks a captured 64-byte default frame starting at queue index qb.
   task automatic chk_frame(input string tag, input int qb, input int bb, input logic [7:0] s);
      int bad;
      bad = 0;
      chk({tag, "_nbytes"}, q.size() - qb, 64);
      chk({tag, "_nbursts"}, blen.size() - bb, 4);
      for (int i = bb; i < blen.size(); i++) if (blen[i] != 16) bad++;
      chk({tag, "_burstlen_errs"}, bad, 0);
      bad = 0;
      for (int i = 0; i < 64 && qb + i < q.size(); i++)
         if (q[qb + i] !== model(i, s, 64)) bad++;
      chk({tag, "_payload_errs"}, bad, 0);
   endtask

   initial begin
      bit   ok;
      int   qb, bb, db, toggles, bad_run, last_t, vs_chg, hs_hi, pairs;
      logic pv, vv;
      logic [7:0] cnt254, cnt255;

      reset     = 1'b0;
      if0.start = 1'b0;
      if0.seed  = 8'h00;
      if1.start = 1'b0;
      if1.seed  = 8'h00;

      // ---------------- reset values ----------------
      repeat (3) @(negedge clk);
      chk("rst_vsync", if0.camera_vsync, 1);
      chk("rst_hsync", if0.camera_hsync, 0);
      chk("rst_pclk",  if0.camera_pclk, 0);
      chk("rst_data",  if0.camera_data, 8'h00);
      chk("rst_busy",  if0.busy, 0);
      chk("rst_done",  if0.frame_done, 0);
      chk("rst_count", if0.frame_count, 0);
      reset = 1'b1;

      toggles = 0; bad_run = 0; last_t = 0; vs_chg = 0; hs_hi = 0;
      pv = 1'b0; vv = if0.camera_vsync;
      for (int n = 1; n <= 16; n++) begin
         @(negedge clk);
         if (if0.camera_pclk !== pv) begin
            toggles++;
            if (n - last_t != 2) bad_run++;
            last_t = n;
         end
         pv = if0.camera_pclk;
         if (if0.camera_vsync !== vv) vs_chg++;
         if (if0.camera_hsync) hs_hi++;
      end
      chk("idle_pclk_toggles", toggles, 8);
      chk("idle_pclk_bad_runs", bad_run, 0);
      chk("idle_vsync_changes", vs_chg, 0);
      chk("idle_hsync_high", hs_hi, 0);

      // ---------------- default frame, seed 0x10 ----------------
      qb = q.size(); bb = blen.size(); db = done_cnt;
      pulse_start0(8'h10);
      chk("f1_busy_rise", if0.busy, 1);
      wait_done0(2000, ok);
      chk("f1_done_seen", ok, 1);
      @(negedge clk);
      chk("f1_frame_clks", t_done - t_vs, 368);
      chk("f1_count", if0.frame_count, 1);
      chk("f1_busy_low", if0.busy, 0);
      chk("f1_done_pulses", done_cnt - db, 1);
      chk_frame("f1", qb, bb, 8'h10);
      chk("f1_b0",  q[qb + 0],  8'hFF);
      chk("f1_b1",  q[qb + 1],  8'hD8);
      chk("f1_b2",  q[qb + 2],  8'h12);
      chk("f1_b61", q[qb + 61], 8'h4D);
      chk("f1_b62", q[qb + 62], 8'hFF);
      chk("f1_b63", q[qb + 63], 8'hD9);

      // ---------------- FF substitution, seed 0xF0 ----------------
      repeat (5) @(negedge clk);
      qb = q.size(); bb = blen.size();
      pulse_start0(8'hF0);
      wait_done0(2000, ok);
      chk("f2_done_seen", ok, 1);
      @(negedge clk);
      chk_frame("f2", qb, bb, 8'hF0);
      chk("f2_b15", q[qb + 15], 8'h00);
      pairs = 0;
      for (int i = 0; i < 62; i++)
         if (q[qb + i] == 8'hFF && q[qb + i + 1] == 8'hD9) pairs++;
      chk("f2_early_eoi", pairs, 0);
      chk("f2_count", if0.frame_count, 2);

      // ---------------- start while busy ----------------
      repeat (5) @(negedge clk);
      qb = q.size(); bb = blen.size(); db = done_cnt;
      pulse_start0(8'h33);
      repeat (100) @(negedge clk);
      pulse_start0(8'h55);
      chk("f3_busy_mid", if0.busy, 1);
      wait_done0(2000, ok);
      chk("f3_done_seen", ok, 1);
      repeat (600) @(negedge clk);
      chk("f3_done_pulses", done_cnt - db, 1);
      chk("f3_busy_after", if0.busy, 0);
      chk("f3_vsync_after", if0.camera_vsync, 1);
      chk("f3_count", if0.frame_count, 3);
      chk_frame("f3", qb, bb, 8'h33);

      // ---------------- reset mid-line ----------------
      qb = q.size(); db = done_cnt;
      pulse_start0(8'h77);
      ok = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clk);
         if (q.size() - qb >= 40) ok = 1'b1;
      end
      chk("rm_reached_line2", ok, 1);
      chk("rm_hsync_before", if0.camera_hsync, 1);
      reset = 1'b0;
      #1;
      chk("rm_vsync", if0.camera_vsync, 1);
      chk("rm_hsync", if0.camera_hsync, 0);
      chk("rm_data",  if0.camera_data, 8'h00);
      chk("rm_busy",  if0.busy, 0);
      chk("rm_count", if0.frame_count, 0);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      chk("rm_no_done", done_cnt - db, 0);
      chk("rm_idle_busy", if0.busy, 0);
      qb = q.size(); bb = blen.size();
      pulse_start0(8'h21);
      wait_done0(2000, ok);
      chk("f4_done_seen", ok, 1);
      @(negedge clk);
      chk_frame("f4", qb, bb, 8'h21);
      chk("f4_count", if0.frame_count, 1);

      // ---------------- counter wrap on the minimal instance ----------------
      cnt254 = 8'hAA; cnt255 = 8'hAA; db = done1_cnt;
      for (int f = 0; f < 256; f++) begin
         if1.start = 1'b1;
         if1.seed  = 8'(f);
         @(negedge clk);
         if1.start = 1'b0;
         wait_done1(200, ok);
         if (!ok) begin
            chk("wrap_done_seen", ok, 1);
            break;
         end
         if (f == 254) cnt254 = if1.frame_count;
         if (f == 255) cnt255 = if1.frame_count;
      end
      @(negedge clk);
      chk("wrap_count_255", cnt254, 8'hFF);
      chk("wrap_count_0", cnt255, 8'h00);
      chk("wrap_done_pulses", done1_cnt - db, 256);
      chk("wrap_done_width", max_run1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/camera_stream_gen.md
# camera_stream_gen

On-chip camera emulator: the transmit end of the DVP-style camera interface consumed by `pixel_input`. On each start request it drives one frame on `camera_vsync`, `camera_hsync`, `camera_pclk` and `camera_data`. The frame is a deterministic JPEG-framed byte stream: `FF D8`, then a seeded payload, then `FF D9`. It substitutes for the physical camera in bring-up and loopback tests of the capture → SRAM → SPI path.

## Interface
- `PCLK_DIV`, default 2: `clk` cycles per `camera_pclk` half-period (≥1).
- `LINES`, default 4: lines per frame (≥1).
- `BYTES_PER_LINE`, default 16: bytes per line. `LINES*BYTES_PER_LINE` must be ≥4.
- `VSYNC_CYCLES`, default 8: pclk periods with vsync asserted (≥1).
- `FRONT_PORCH`, default 4: pclk periods from vsync deassert to the first line (≥1).
- `LINE_GAP`, default 4: pclk periods with hsync low after each line (≥1).
- `VSYNC_ACTIVE`, default 0: asserted level of `camera_vsync`.
- `clk` (input, 1): system clock. This is the single clock.
- `reset` (input, 1): asynchronous, active-low reset.
- `start` (input, 1): one-clk request to emit a frame. Ignored while `busy`.
- `seed` (input, 8): payload seed. Sampled on the accepted `start`.
- `camera_vsync` (output, 1): frame sync.
- `camera_hsync` (output, 1): HREF. High while a byte is valid.
- `camera_pclk` (output, 1): pixel clock, free-running.
- `camera_data` (output, 8): stream byte.
- `busy` (output, 1): high from the accepted `start` until the frame completes.
- `frame_done` (output, 1): one-clk pulse at frame end.
- `frame_count` (output, 8): frames completed. Wraps 255→0.

## Operation
- **pclk generation**
  - A divider toggles `camera_pclk` every `PCLK_DIV` clk cycles. It runs in every state after reset.
  - A *fall tick* is the clk cycle in which `camera_pclk` is driven 1→0. All state transitions and all changes to vsync, hsync and data happen only on fall ticks. The receiver samples on the rising edge, so data is stable across it.
- **States**
  - IDLE: vsync inactive, hsync 0, data 0x00. An accepted `start` latches `seed`, sets `busy` and arms the sequencer. The sequencer moves to VSYNC at the next fall tick.
  - VSYNC: vsync = `VSYNC_ACTIVE` for `VSYNC_CYCLES` periods, then FRONT.
  - FRONT: vsync inactive for `FRONT_PORCH` periods, then LINE.
  - LINE: hsync 1 for `BYTES_PER_LINE` periods, one byte per period. Then GAP.
  - GAP: hsync 0 and data 0x00 for `LINE_GAP` periods.
    - If lines remain, go to LINE.
    - Otherwise go to IDLE: `busy` drops, `frame_done` pulses, and `frame_count` increments, all on that same fall tick.
- **Byte k** of the frame, with k counting 0..N-1 across lines and N = `LINES*BYTES_PER_LINE`:
  - k=0 → 0xFF; k=1 → 0xD8.
  - k=N-2 → 0xFF; k=N-1 → 0xD9.
  - Otherwise → `(seed + k) mod 256`, with the result 0xFF replaced by 0x00. The payload therefore never contains 0xFF, so no false `FF D9` can appear.
  - k is an internal counter wide enough for N. The payload uses only its low 8 bits.
- **Boundary conditions**
  - `start` while busy: dropped, not queued. `seed` is not resampled.
  - `start` on the same clk as the final fall tick: ignored, because `busy` is still 1 in that cycle.
  - Reset mid-frame: outputs return to their reset values immediately and the frame is abandoned. `frame_done` does not pulse.

## Timing
- **Reset values**
  - `camera_vsync` = `~VSYNC_ACTIVE`.
  - `camera_hsync` = 0, `camera_pclk` = 0, `camera_data` = 0x00.
  - `busy` = 0, `frame_done` = 0, `frame_count` = 0.
- All outputs are registered.
- `busy` rises on the clk after `start`. vsync asserts at the first fall tick after that, so the latency is ≤ 2·`PCLK_DIV`+1 clks.
- pclk period = 2·`PCLK_DIV` clks.
- Frame length, measured from vsync assert to the `frame_done` tick, is `VSYNC_CYCLES + FRONT_PORCH + LINES*(BYTES_PER_LINE+LINE_GAP)` pclk periods.
- Each byte is held for exactly one pclk period. hsync rises with byte 0 of a line and falls on the fall tick after its last byte.

## Test plan
- **Reset values:** hold `reset` low, then release. Required: all outputs at reset values; pclk toggles every 2 clks; vsync stays 1 and hsync stays 0 with no `start`.
- **Default frame, seed=0x10:** capture on pclk rising edges. Required:
  - 64 bytes in 4 bursts of 16.
  - byte0=0xFF, byte1=0xD8, byte2=0x12, byte61=0x4D, byte62=0xFF, byte63=0xD9.
  - 92 pclk periods (368 clks) from vsync low to `frame_done`.
  - `frame_count`=1.
- **FF substitution, seed=0xF0:** required byte15 = 0x00 (not 0xFF); no `FF D9` pair before bytes 62–63.
- **start while busy:** pulse `start` with seed=0x55 mid-frame. Required: the frame continues with the original seed; exactly one `frame_done`; no second frame starts.
- **Reset mid-line:** assert `reset` during line 2. Required: vsync=1, hsync=0, data=0x00 and `busy`=0 immediately; no `frame_done`; a following `start` yields a complete, correct frame.
- **Counter wrap:** run 256 back-to-back frames. Required: `frame_count` goes 255→0; `frame_done` pulses are one clk wide.
